comp_instr_packer: RTL and testbench
====================================

// Module: comp_instr_packer
// PURPOSE
//  Write-side counterpart of the fetch-path decompressor: packs a stream of RV32IC
//  instructions (16-bit compressed or 32-bit full) into aligned 32-bit memory words.
//  Packing is little-endian by halfword, so the decompressor's unpack FSM recovers the
//  original stream. Sits between the boot/trace instruction source and the instruction RAM
//  write port; valid/ready on both sides.
// PARAMETERS
//  PAD_HALF   16'h0001  halfword used to pad a trailing odd half (c.nop)
//  CNT_W      16        width of statistics counters (COMP_PACK_STATS_EN only)
// PORTS
//  aclk        in   1      clock, all state on rising edge
//  aresetn     in   1      asynchronous active-low reset
//  in_valid    in   1      in_instr is valid
//  in_ready    out  1      packer accepts in_instr this cycle
//  in_instr    in   32     instruction; compressed iff in_instr[1:0]!=2'b11 (upper 16 ignored)
//  in_last     in   1      with in_valid: final instruction; flush any pending half
//  out_valid   out  1      out_word is valid
//  out_ready   in   1      downstream accepts out_word
//  out_word    out  32     packed word, [15:0]=lower address halfword
//  out_last    out  1      marks final word of a stream
//  word_cnt    out  CNT_W  words emitted (COMP_PACK_STATS_EN only)
//  cmp_cnt     out  CNT_W  compressed instructions accepted (COMP_PACK_STATS_EN only)
// BEHAVIOUR
//  - Reset: state=EMPTY, hold=0, out_valid=0, out_word=0, out_last=0, counters=0, in_ready=1.
//  - Output is a single registered slot; slot_free = !out_valid || out_ready.
//  - in_ready = slot_free && state!=PAD. Input accepted (fire) when in_valid && in_ready.
//  - States: EMPTY (no pending half), HALF (hold[15:0] pending), PAD (emit pad word).
//  - On fire, 16-bit instr c=in_instr[15:0]; 32-bit instr f=in_instr:
//    EMPTY,16b,!last -> hold=c, HALF, no output.
//    EMPTY,16b,last  -> out {PAD_HALF,c}, out_last=1, EMPTY.
//    EMPTY,32b       -> out f, out_last=in_last, EMPTY.
//    HALF,16b        -> out {c,hold}, out_last=in_last, EMPTY.
//    HALF,32b,!last  -> out {f[15:0],hold}, hold=f[31:16], HALF.
//    HALF,32b,last   -> out {f[15:0],hold}, out_last=0, hold=f[31:16], PAD.
//    PAD (when slot_free) -> out {PAD_HALF,hold}, out_last=1, EMPTY.
//  - Latency: an emitting fire gives out_valid the next cycle; 32-bit in EMPTY is 1 cycle.
//  - out_word/out_last hold stable while out_valid && !out_ready; no input accepted then.
//  - Back-to-back: with out_ready=1, one input per cycle; PAD inserts exactly 1 bubble.
//  - When out_valid && out_ready and no new emit that cycle, out_valid deasserts next cycle.
//  - in_last with no pending half and no emission never occurs (every last emits).
//  - Async reset mid-stream discards hold and any unaccepted out_word; no pad emitted.
//  - in_instr[31:16] for compressed input ignored, never appears in out_word.
// CONFIGURATION
//  - COMP_PACK_STATS_EN defined: word_cnt increments on each out_valid&&out_ready;
//    cmp_cnt increments on each fire of a compressed instr; both wrap modulo 2^CNT_W;
//    both clear on reset.
//  - Undefined: word_cnt/cmp_cnt ports absent, no counter logic; packing identical.
// TESTING
//  - 32b 0x00000013 in EMPTY, out_ready=1 -> next cycle out_word=0x00000013, out_last=0.
//  - 16b 0x4505 then 16b 0x0505 -> one word 0x05054505 after 2nd fire; no output after 1st.
//  - 16b 0x4505, 32b 0x00A00093, 16b 0x8082(last) -> 0x00934505, then 0x808200A0 last=1.
//  - 16b 0x4505, 32b 0x00A00093(last) -> 0x00934505 (last=0), 0x000100A0 (last=1),
//    in_ready=0 during PAD cycle.
//  - out_ready=0 for 5 cycles with out_valid=1 -> out_word stable, in_ready=0, no loss.
//  - aresetn low while HALF holding 0x4505 -> out_valid=0, next 32b 0x00000013 emits as-is;
//    with COMP_PACK_STATS_EN, 3 compressed + 2 words seen -> cmp_cnt=3, word_cnt=2.

Source files
------------

// File: rtl/comp_instr_packer.sv
// comp_instr_packer: packs a stream of RV32IC instructions (16-bit compressed or
// 32-bit full) into aligned 32-bit words, little-endian by halfword.
// A trailing odd halfword at in_last is padded with PAD_HALF.
//
// Optional feature macro: COMP_PACK_STATS_EN adds the word_cnt / cmp_cnt counters
// and the CNT_W parameter.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_instr (compressed iff [1:0]!=2'b11), in_last
//   out_valid/out_ready  output handshake; out_word ([15:0] = lower address), out_last
//   word_cnt, cmp_cnt    words emitted / compressed instructions accepted (stats only)
module comp_instr_packer #(
  parameter logic [15:0] PAD_HALF = 16'h0001
`ifdef COMP_PACK_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last
`ifdef COMP_PACK_STATS_EN
  , output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] cmp_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_PAD   = 2'd2
  } state_e;

  state_e      state, state_d;
  logic [15:0] hold, hold_d;
  logic        out_valid_d;
  logic [31:0] out_word_d;
  logic        out_last_d;

  logic slot_free;
  logic fire;
  logic is_comp;

  // The output slot can take a new word when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state != ST_PAD);
  assign fire      = in_valid && in_ready;
  assign is_comp   = (in_instr[1:0] != 2'b11);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    hold_d      = hold;
    out_valid_d = out_valid && !out_ready;
    out_word_d  = out_word;
    out_last_d  = out_last;
    unique case (state)
      ST_EMPTY: begin
        if (fire) begin
          if (is_comp) begin
            if (in_last) begin
              out_valid_d = 1'b1;
              out_word_d  = {PAD_HALF, in_instr[15:0]};
              out_last_d  = 1'b1;
            end else begin
              hold_d  = in_instr[15:0];
              state_d = ST_HALF;
            end
          end else begin
            out_valid_d = 1'b1;
            out_word_d  = in_instr;
            out_last_d  = in_last;
          end
        end
      end
      ST_HALF: begin
        if (fire) begin
          out_valid_d = 1'b1;
          if (is_comp) begin
            out_word_d = {in_instr[15:0], hold};
            out_last_d = in_last;
            state_d    = ST_EMPTY;
          end else begin
            // Upper half of a straddling 32-bit instruction stays pending.
            out_word_d = {in_instr[15:0], hold};
            out_last_d = 1'b0;
            hold_d     = in_instr[31:16];
            state_d    = in_last ? ST_PAD : ST_HALF;
          end
        end
      end
      ST_PAD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_word_d  = {PAD_HALF, hold};
          out_last_d  = 1'b1;
          state_d     = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_EMPTY;
      hold      <= 16'h0000;
      out_valid <= 1'b0;
      out_word  <= 32'h0000_0000;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      out_valid <= out_valid_d;
      out_word  <= out_word_d;
      out_last  <= out_last_d;
    end
  end

`ifdef COMP_PACK_STATS_EN
  // Statistics counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_cnt <= '0;
      cmp_cnt  <= '0;
    end else begin
      if (out_valid && out_ready) word_cnt <= word_cnt + CNT_W'(1);
      if (fire && is_comp)        cmp_cnt  <= cmp_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_comp_instr_packer.sv
// Testbench for comp_instr_packer: directed vector table, hand-written
// backpressure/reset sequences, and randomized traffic against a halfword-queue model.
module tb_comp_instr_packer;

  logic        aclk;
  logic        aresetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
`ifdef COMP_PACK_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] cmp_cnt;
`endif

  comp_instr_packer dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last)
`ifdef COMP_PACK_STATS_EN
    , .word_cnt (word_cnt),
    .cmp_cnt   (cmp_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: stream of halfwords in address order; flag marks the
  // final halfword of a stream. Words are formed from consecutive pairs.
  logic [15:0] hq[$];
  bit          fq[$];
  bit          fired;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] instr, input bit last);
    if (instr[1:0] != 2'b11) begin
      hq.push_back(instr[15:0]); fq.push_back(last);
    end else begin
      hq.push_back(instr[15:0]);  fq.push_back(1'b0);
      hq.push_back(instr[31:16]); fq.push_back(last);
    end
    if (last && (hq.size() % 2 == 1)) begin
      hq.push_back(16'h0001); fq.push_back(1'b1);
    end
  endtask

  task automatic model_pop();
    logic [31:0] w;
    logic        l;
    if (hq.size() < 2) begin
      checks++;
      errors++;
      $display("FAIL unexpected_word: got %h expected none", out_word);
    end else begin
      w = {hq[1], hq[0]};
      l = fq[1];
      void'(hq.pop_front()); void'(hq.pop_front());
      void'(fq.pop_front()); void'(fq.pop_front());
      chk("sb_word", out_word, w);
      chk("sb_last", 32'(out_last), 32'(l));
    end
  endtask

  task automatic model_clear();
    hq.delete();
    fq.delete();
  endtask

  // Inputs set at a negedge; resolve handshakes, advance one clock, return at next negedge.
  task automatic tick();
    #1;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) model_pop();
    if (fired) model_push(in_instr, in_last);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    model_clear();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic        last;
    logic        exp_v;
    logic [31:0] exp_w;
    logic        exp_l;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    fired     = 1'b0;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_word", out_word, 32'h0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef COMP_PACK_STATS_EN
    chk("reset_word_cnt", 32'(word_cnt), 32'd0);
    chk("reset_cmp_cnt", 32'(cmp_cnt), 32'd0);
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Directed stream, out_ready held high.
    tbl[0]  = '{1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 32'h0000_4505, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h0000_0505, 1'b0, 1'b1, 32'h0505_4505, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 32'h0000_4505, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h00A0_0093, 1'b0, 1'b1, 32'h0093_4505, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 32'h0000_8082, 1'b1, 1'b1, 32'h8082_00A0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 32'h0000_4505, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h00A0_0093, 1'b1, 1'b1, 32'h0093_4505, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0001_00A0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 32'hFFFF_4505, 1'b1, 1'b1, 32'h0001_4505, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].vld;
      in_instr = tbl[i].instr;
      in_last  = tbl[i].last;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk($sformatf("vec%0d_word", i), out_word, tbl[i].exp_w);
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].exp_l));
      end
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
    end
    in_valid = 1'b0;

    // Backpressure: output held for 5 cycles, pending input not accepted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000_0013;
    in_last   = 1'b0;
    tick();
    in_instr = 32'h1234_5677;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_word", out_word, 32'h0000_0013);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_fire_after_release", 32'(fired), 32'd1);
    chk("bp_next_word", out_word, 32'h1234_5677);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Async reset while a half is pending.
    in_valid = 1'b1;
    in_instr = 32'h0000_4505;
    in_last  = 1'b0;
    tick();
    in_valid = 1'b0;
    aresetn  = 1'b0;
    #2;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    model_clear();
    @(negedge aclk);
    aresetn  = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_0013;
    tick();
    chk("rst_after_valid", 32'(out_valid), 32'd1);
    chk("rst_after_word", out_word, 32'h0000_0013);
    chk("rst_after_last", 32'(out_last), 32'd0);
    in_valid = 1'b0;
    tick();

`ifdef COMP_PACK_STATS_EN
    // Counters: 3 compressed instructions, 2 words consumed.
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h0000_4505; in_last = 1'b0; tick();
    in_instr = 32'h0000_0505; in_last = 1'b0; tick();
    in_instr = 32'h0000_4505; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("stats_cmp_cnt", 32'(cmp_cnt), 32'd3);
    chk("stats_word_cnt", 32'(word_cnt), 32'd2);
`endif

    // Randomized traffic against the halfword-queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] h;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_last   = ($urandom % 10) == 0;
      if ($urandom % 2) begin
        h = 16'($urandom);
        if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        in_instr = {16'($urandom), h};
      end else begin
        in_instr = {30'($urandom), 2'b11};
      end
      tick();
    end

    // Close the stream with a final compressed instruction, then drain.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_instr = 32'h0000_4505;
    out_ready = 1'b1;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) tick();
    chk("final_fire", 32'(fired), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 10 && (out_valid || hq.size() != 0); i++) tick();
    chk("drain_model_empty", 32'(hq.size()), 32'd0);
    chk("drain_out_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
